// File: rtl/button_pkg.sv
// button_pkg: shared constants and FSM state type for the button debouncer.
package button_pkg;
  localparam int NUM_BTN = 3;
  localparam int DEF_SAMPLE_DIV = 12000;
  localparam int DEF_STABLE_SAMPLES = 10;
  localparam int DEF_LONG_SAMPLES = 1000;
  typedef enum logic {ST_STABLE, ST_CHANGING} state_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button's synchroniser, stable-sample FSM and edge pulses.
// The long-press hold counter exists only with BUTTON_DEBOUNCER_LONG_PRESS_EN defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int LONG_SAMPLES = DEF_LONG_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic held
);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SAMPLES);
  logic [1:0] sync;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, nxt;
  logic diff, flip;
  if (STABLE_SAMPLES < 1 || LONG_SAMPLES < 1) begin : g_bad_cfg
    $error("debounce_channel: STABLE_SAMPLES and LONG_SAMPLES must be >= 1");
  end
  always_comb begin
    diff = tick && (sync[1] != level);
    nxt = (state == ST_STABLE) ? CW'(1) : cnt + 1'b1;
    flip = diff && (nxt == CNT_MAX);
    state_d = !tick ? state : (diff && !flip) ? ST_CHANGING : ST_STABLE;
    cnt_d = !tick ? cnt : (diff && !flip) ? nxt : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      state <= ST_STABLE;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      state <= state_d;
      cnt <= cnt_d;
      level <= level ^ flip;
      press <= flip && !level;
      rel <= flip && level;
    end
  end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_SAMPLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_SAMPLES);
  logic [HW-1:0] hold;
  // Saturating at HOLD_MAX guarantees a single long pulse per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      held <= 1'b0;
    end else begin
      held <= tick && level && (hold == HOLD_MAX - 1'b1);
      hold <= !level ? '0 : (tick && hold != HOLD_MAX) ? hold + 1'b1 : hold;
    end
  end
`else
  assign held = 1'b0;
`endif
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: shared sample-tick divider feeding NUM_BTN debounce channels.
// Long-press pulses are generated only with BUTTON_DEBOUNCER_LONG_PRESS_EN defined.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int LONG_SAMPLES = DEF_LONG_SAMPLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN1,
  input  logic BTN2,
  input  logic BTN3,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE,
  output logic [NUM_BTN-1:0] BTN_LONG
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] DIV_LAST = TW'(SAMPLE_DIV - 1);
  logic [TW-1:0] div;
  logic tick;
  logic [NUM_BTN-1:0] btn;
  if (SAMPLE_DIV < 2) begin : g_bad_cfg
    $error("button_debouncer: SAMPLE_DIV must be >= 2");
  end
  assign tick = div == DIV_LAST;
  assign btn = {BTN3, BTN2, BTN1};
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
  end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .LONG_SAMPLES(LONG_SAMPLES)
    ) u_ch (
      .clk(CLK),
      .rst_n(RST_N),
      .btn(btn[i]),
      .tick(tick),
      .level(BTN_LEVEL[i]),
      .press(BTN_PRESS[i]),
      .rel(BTN_RELEASE[i]),
      .held(BTN_LONG[i])
    );
  end
endmodule
